cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_run_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ==========================================================================
// cpu_pkg : shared CPU run-control types and the machine word width
// Rev 1.0
// ==========================================================================
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    RUN      = 3'd2,
    BREAK    = 3'd3,
    HALTED   = 3'd4,
    TIMEOUT  = 3'd5
  } run_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ==========================================================================
// cpu_run_ctrl : start/reset/step/breakpoint/timeout sequencer for a CPU core
// Rev 1.0
// ==========================================================================
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100,
  parameter int CNT_W      = 32,
  parameter int XLEN       = cpu_pkg::XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             halt_in,
  input  logic [XLEN-1:0]  pc,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             timeout,
  output logic             bp_hit
);

  localparam int HOLD_CYCLES = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              bp_hit_q, bp_hit_d;

  logic              bp_match;
  logic              can_start;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    bp_match  = bp_en && (pc == bp_addr);
    can_start = start && (state_q inside {IDLE, BREAK, HALTED, TIMEOUT});
    cpu_rst   = (state_q == IDLE) || (state_q == RST_HOLD);

    // A restart request in BREAK wins over a same-cycle step.
    case (state_q)
      RUN:     cpu_en = !bp_match && (!step_mode || step_req);
      BREAK:   cpu_en = step_req && !start;
      default: cpu_en = 1'b0;
    endcase

    cnt_inc = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

    state_d     = state_q;
    hold_d      = hold_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    bp_hit_d    = bp_hit_q;

    if (can_start) begin
      state_d     = RST_HOLD;
      hold_d      = '0;
      cycle_cnt_d = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      bp_hit_d    = 1'b0;
    end else if (state_q == RST_HOLD) begin
      if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
        state_d = RUN;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end else if (cpu_en) begin
      // Halt is checked first so a halt on the last budgeted cycle is a clean stop.
      cycle_cnt_d = cnt_inc;
      if (halt_in) begin
        state_d = HALTED;
        done_d  = 1'b1;
      end else if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
        state_d   = TIMEOUT;
        timeout_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && bp_match) begin
      state_d  = BREAK;
      bp_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      bp_hit_q    <= bp_hit_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign bp_hit    = bp_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_cpu_run_ctrl : directed + randomized bench with a cycle-level reference model
// Rev 1.0
// ==========================================================================
module tb_cpu_run_ctrl;

  localparam int MAXC = 10;
  localparam int RSTC = 2;

  localparam int P_IDLE = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN  = 2;
  localparam int P_BRK  = 3;
  localparam int P_HALT = 4;
  localparam int P_TOUT = 5;

  logic        clk = 1'b0;
  logic        reset, start, step_mode, step_req, halt_in, bp_en;
  logic [31:0] pc, bp_addr;
  logic        cpu_rst, cpu_en, done, timeout, bp_hit;
  logic [31:0] cycle_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RST_CYCLES (RSTC),
    .MAX_CYCLES (MAXC),
    .CNT_W      (32),
    .XLEN       (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step_mode (step_mode),
    .step_req  (step_req),
    .halt_in   (halt_in),
    .pc        (pc),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .cpu_rst   (cpu_rst),
    .cpu_en    (cpu_en),
    .cycle_cnt (cycle_cnt),
    .done      (done),
    .timeout   (timeout),
    .bp_hit    (bp_hit)
  );

  // Reference model: phase, remaining hold cycles, enabled-cycle count, sticky flags
  int     ph;
  int     hold_left;
  longint m_cnt;
  bit     m_done, m_to, m_bp;

  task automatic model_reset();
    ph = P_IDLE; hold_left = 0; m_cnt = 0;
    m_done = 1'b0; m_to = 1'b0; m_bp = 1'b0;
  endtask

  function automatic bit exp_en();
    bit hit;
    hit = bp_en && (pc == bp_addr);
    if (ph == P_RUN) return !hit && (!step_mode || step_req);
    if (ph == P_BRK) return step_req && !start;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit en;
    en = exp_en();
    if (reset) begin
      model_reset();
    end else if (start && (ph == P_IDLE || ph == P_BRK || ph == P_HALT || ph == P_TOUT)) begin
      ph = P_HOLD; hold_left = RSTC; m_cnt = 0;
      m_done = 1'b0; m_to = 1'b0; m_bp = 1'b0;
    end else if (ph == P_HOLD) begin
      hold_left--;
      if (hold_left <= 0) ph = P_RUN;
    end else if (en) begin
      if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
      if (halt_in) begin
        ph = P_HALT; m_done = 1'b1;
      end else if (m_cnt == MAXC) begin
        ph = P_TOUT; m_to = 1'b1;
      end else begin
        ph = P_RUN;
      end
    end else if (ph == P_RUN && bp_en && pc == bp_addr) begin
      ph = P_BRK; m_bp = 1'b1;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string where);
    chk({where, ":cpu_rst"},   64'(cpu_rst),   64'(ph == P_IDLE || ph == P_HOLD));
    chk({where, ":cpu_en"},    64'(cpu_en),    64'(exp_en()));
    chk({where, ":cycle_cnt"}, 64'(cycle_cnt), 64'(m_cnt));
    chk({where, ":done"},      64'(done),      64'(m_done));
    chk({where, ":timeout"},   64'(timeout),   64'(m_to));
    chk({where, ":bp_hit"},    64'(bp_hit),    64'(m_bp));
  endtask

  task automatic cycle(string where);
    @(negedge clk);
    check_all(where);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(string where);
    start = 1'b1;
    cycle(where);
    start = 1'b0;
  endtask

  initial begin
    int brk_seen;
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    halt_in = 1'b0; bp_en = 1'b0; pc = '0; bp_addr = 32'h0000_0010;
    model_reset();
    #1;

    for (int i = 0; i < 3; i++) cycle("reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle("idle_no_start");

    // Free run, halt on the 7th enabled cycle
    pulse_start("s25_start");
    for (int i = 0; i < 30 && ph != P_HALT; i++) begin
      halt_in = (ph == P_RUN) && (m_cnt == 6);
      pc = 32'(m_cnt * 4);
      cycle("s25_run");
    end
    halt_in = 1'b0;
    for (int i = 0; i < 3; i++) cycle("s25_after");
    chk("s25_done", 64'(done), 64'd1);
    chk("s25_cnt", 64'(cycle_cnt), 64'd7);

    // Budget exhaustion without halt
    pulse_start("s26_start");
    for (int i = 0; i < 20; i++) cycle("s26_run");
    chk("s26_timeout", 64'(timeout), 64'd1);
    chk("s26_cnt", 64'(cycle_cnt), 64'd10);
    chk("s26_done", 64'(done), 64'd0);

    // Halt coinciding with the last budgeted cycle
    pulse_start("s27_start");
    for (int i = 0; i < 20 && ph != P_HALT; i++) begin
      halt_in = (ph == P_RUN) && (m_cnt == 9);
      cycle("s27_run");
    end
    halt_in = 1'b0;
    cycle("s27_after");
    chk("s27_done", 64'(done), 64'd1);
    chk("s27_timeout", 64'(timeout), 64'd0);

    // Breakpoint at 0x10, one step out of BREAK, then run resumes
    bp_en = 1'b1; bp_addr = 32'h0000_0010; brk_seen = 0;
    pulse_start("s28_start");
    for (int i = 0; i < 25; i++) begin
      pc = 32'(m_cnt * 4);
      if (ph == P_BRK) brk_seen++;
      step_req = (ph == P_BRK) && (brk_seen == 3);
      cycle("s28_run");
    end
    step_req = 1'b0; bp_en = 1'b0;
    chk("s28_bp_hit", 64'(bp_hit), 64'd1);
    chk("s28_timeout", 64'(timeout), 64'd1);

    // Single-step: three pulses, then a 2-cycle held request
    step_mode = 1'b1;
    pulse_start("s29_start");
    for (int i = 0; i < 12; i++) begin
      step_req = (i == 3) || (i == 6) || (i == 9);
      cycle("s29_step");
    end
    step_req = 1'b0;
    chk("s29_cnt", 64'(cycle_cnt), 64'd3);
    step_req = 1'b1;
    cycle("s29_hold");
    cycle("s29_hold");
    step_req = 1'b0;
    cycle("s29_hold");
    chk("s29_cnt_held", 64'(cycle_cnt), 64'd5);
    step_mode = 1'b0;

    // Asynchronous reset in the middle of a run, then restart from zero
    reset = 1'b1;
    model_reset();
    cycle("s30_pre");
    reset = 1'b0;
    pulse_start("s30_start");
    for (int i = 0; i < 20 && m_cnt < 5; i++) cycle("s30_run");
    reset = 1'b1;
    #2;
    model_reset();
    check_all("s30_async");
    chk("s30_cnt_zero", 64'(cycle_cnt), 64'd0);
    cycle("s30_in_reset");
    reset = 1'b0;
    cycle("s30_idle");
    pulse_start("s30_restart");
    for (int i = 0; i < 6; i++) cycle("s30_rerun");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      start = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      step_req = ($urandom_range(0, 2) == 0);
      halt_in  = ($urandom_range(0, 19) == 0);
      bp_en    = ($urandom_range(0, 3) == 0);
      bp_addr  = 32'h0000_0010;
      pc       = $urandom_range(0, 1) ? 32'h0000_0010 : $urandom;
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
